// File: rtl/bcd_display_scanner_if.sv
// ============================================================================
// Module  : bcd_display_scanner_if
// Brief   : Bus bundle between a BCD value source and the display scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    pending;
  logic                    frame_tick;

  modport master (
    output value_in,
    output load,
    input  bcd_out,
    input  anode,
    input  pending,
    input  frame_tick
  );

  modport slave (
    input  value_in,
    input  load,
    output bcd_out,
    output anode,
    output pending,
    output frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/bcd_display_scanner.sv
// ============================================================================
// Module  : bcd_display_scanner
// Brief   : Time-multiplexed 7-segment scan controller with a double-buffered
//           BCD value. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int PRESCALE         = 100000,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  bcd_display_scanner_if.slave   bus
);

  localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [c_PW-1:0]       c_PRESC_LAST = c_PW'(PRESCALE - 1);
  localparam logic [c_IW-1:0]       c_IDX_LAST   = c_IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_ANODE_OFF  = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

  logic [c_PW-1:0]         r_presc;
  logic [c_IW-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic                    r_pending;
  logic                    r_frame_tick;
  logic [3:0]              r_bcd;
  logic [NUM_DIGITS-1:0]   r_anode;

  logic                    w_tc;
  logic                    w_fb;
  logic [3:0]              w_digits [NUM_DIGITS];
  wire  [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS-1:0]   w_onehot;

  assign w_tc     = (r_presc == c_PRESC_LAST);
  assign w_fb     = w_tc && (r_idx == c_IDX_LAST);
  assign w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign w_digits[g] = r_active[4*g +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and everything above it is zero; the units digit always shows.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_blank
    if (g == 0) begin : g_lsd
      assign w_blank[g] = 1'b0;
    end else begin : g_upper
      assign w_blank[g] = (r_active[4*NUM_DIGITS-1:4*g] == '0);
    end
  end
`else
  assign w_blank = '0;
`endif

  // Scan timebase: prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tc ? '0 : r_presc + c_PW'(1);
      if (w_tc) begin
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IW'(1);
      end
    end
  end

  // Double buffer: loads land in the shadow and only reach the display at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_fb;
      if (bus.load) begin
        r_shadow <= bus.value_in;
      end
      if (w_fb) begin
        if (bus.load) begin
          r_active  <= bus.value_in;
          r_pending <= 1'b0;
        end else if (r_pending) begin
          r_active  <= r_shadow;
          r_pending <= 1'b0;
        end
      end else if (bus.load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd   <= 4'hF;
      r_anode <= c_ANODE_OFF;
    end else begin
      r_anode <= w_onehot ^ c_ANODE_OFF;
      r_bcd   <= w_blank[r_idx] ? 4'hF : w_digits[r_idx];
    end
  end

  assign bus.bcd_out    = r_bcd;
  assign bus.anode      = r_anode;
  assign bus.pending    = r_pending;
  assign bus.frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
// ============================================================================
// Module  : tb_bcd_display_scanner
// Brief   : Self-checking bench for bcd_display_scanner (4 digits, prescale 4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_scanner;

  localparam int ND = 4;
  localparam int PS = 4;
  localparam int FRAME = ND * PS;

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  bcd_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  bcd_display_scanner #(
    .NUM_DIGITS      (ND),
    .PRESCALE        (PS),
    .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: scan position follows from the number of edges since reset.
  int          m_n;
  logic [15:0] m_shadow, m_active;
  bit          m_pending;
  logic [3:0]  e_anode, e_bcd;
  bit          e_tick;

  function automatic bit blank_digit(int k, logic [15:0] v);
`ifdef LEADING_ZERO_BLANK_EN
    return (k >= 1) && ((v >> (4 * k)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_shadow = '0; m_active = '0; m_pending = 0;
      e_anode = 4'b1111; e_bcd = 4'hF; e_tick = 0;
    end else begin
      int  idx;
      bit  fb;
      idx = (m_n / PS) % ND;
      fb  = (m_n % FRAME) == FRAME - 1;
      e_anode = ~(4'b0001 << idx);
      e_bcd   = blank_digit(idx, m_active) ? 4'hF : 4'((m_active >> (4 * idx)) & 16'hF);
      e_tick  = fb;
      if (bus.load) begin
        m_shadow = bus.value_in;
        if (fb) m_active = bus.value_in;
        m_pending = !fb;
      end else if (fb && m_pending) begin
        m_active  = m_shadow;
        m_pending = 0;
      end
      m_n++;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("anode", 32'(bus.anode), 32'(e_anode));
      chk("bcd_out", 32'(bus.bcd_out), 32'(e_bcd));
      chk("pending", 32'(bus.pending), 32'(m_pending));
      chk("frame_tick", 32'(bus.frame_tick), 32'(e_tick));
    end
  end

  initial begin
    @(posedge clk);
    #1 chk_en = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_load(logic [15:0] v);
    bus.value_in = v;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_tick(output int waited);
    waited = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      waited++;
      if (e_tick) return;
    end
    chk("wait_tick_timeout", 32'(waited), 32'(0));
  endtask

  task automatic wait_fb_next();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ((m_n % FRAME) == FRAME - 1) return;
      @(negedge clk);
    end
    chk("wait_fb_timeout", 32'(1), 32'(0));
  endtask

  // Records what each digit position displays over one full frame.
  task automatic scan_frame(output logic [15:0] seen);
    seen = 'x;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++)
        if (bus.anode[k] == 1'b0) seen[4*k +: 4] = bus.bcd_out;
    end
  endtask

  initial begin
    int          w, w2;
    logic [15:0] seen;
    int          r;
    rst_n = 1'b0;
    bus.load = 1'b0;
    bus.value_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_anode", 32'(bus.anode), 32'h0000_000F);
    chk("rst_bcd", 32'(bus.bcd_out), 32'h0000_000F);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_anode", 32'(bus.anode), 32'h0000_000E);
    chk("first_bcd", 32'(bus.bcd_out), 32'h0);

    wait_tick(w);
    wait_tick(w2);
    chk("tick_period", 32'(w2), 32'd16);

    repeat (3) @(negedge clk);
    do_load(16'h1234);
    chk("pend_after_load", 32'(bus.pending), 32'h1);
    wait_tick(w);
    chk("pend_after_fb", 32'(bus.pending), 32'h0);
    scan_frame(seen);
    chk("frame_1234", 32'(seen), 32'h1234);

    wait_fb_next();
    do_load(16'h5678);
    chk("pend_load_on_fb", 32'(bus.pending), 32'h0);
    scan_frame(seen);
    chk("frame_5678", 32'(seen), 32'h5678);

    repeat (2) @(negedge clk);
    do_load(16'h1111);
    @(negedge clk);
    do_load(16'h2222);
    wait_tick(w);
    scan_frame(seen);
    chk("frame_last_wins", 32'(seen), 32'h2222);

    do_load(16'h0050);
    wait_tick(w);
    scan_frame(seen);
`ifdef LEADING_ZERO_BLANK_EN
    chk("frame_0050", 32'(seen), 32'hFF50);
`else
    chk("frame_0050", 32'(seen), 32'h0050);
`endif
    do_load(16'h0000);
    wait_tick(w);
    scan_frame(seen);
`ifdef LEADING_ZERO_BLANK_EN
    chk("frame_0000", 32'(seen), 32'hFFF0);
`else
    chk("frame_0000", 32'(seen), 32'h0000);
`endif

    repeat (2) @(negedge clk);
    do_load(16'h9999);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_anode", 32'(bus.anode), 32'h0000_000F);
    chk("midrst_bcd", 32'(bus.bcd_out), 32'h0000_000F);
    chk("midrst_pending", 32'(bus.pending), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_pending", 32'(bus.pending), 32'h0);
    wait_tick(w);
    scan_frame(seen);
`ifdef LEADING_ZERO_BLANK_EN
    chk("frame_after_rst", 32'(seen), 32'hFFF0);
`else
    chk("frame_after_rst", 32'(seen), 32'h0000);
`endif

    // Random phase: sparse values for blanking, loads aimed at frame boundaries, async resets.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 3))
        0:       bus.value_in = 16'($urandom);
        1:       bus.value_in = 16'($urandom) & 16'h00FF;
        2:       bus.value_in = 16'($urandom) & 16'h0F00;
        default: bus.value_in = 16'($urandom) & 16'h000F;
      endcase
      bus.load = (r < 12) || (((m_n % FRAME) == FRAME - 1) && (r < 50));
      if (r == 99) begin
        bus.load = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.load = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
